// File: rtl/prm_pkg.sv
// Shared types and defaults for the pulse-rate meter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package prm_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ALARM   = 2'd3
  } state_e;

  localparam int unsigned DEF_CLK_HZ   = 100_000_000;
  localparam int unsigned DEF_WINDOW_S = 60;
  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned DEF_DEB_CYC  = 1000;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prm_tick_gen.sv
// Second tick and measurement-window timer for the pulse-rate meter.
// Latency: combinational sec_tick/win_end from registered counters.
// Backpressure: none; both counters hold at zero while run is low.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   run      counters advance only while high, cleared otherwise
//   sec_tick one-cycle strobe every CLK_HZ cycles of run
//   win_end  sec_tick that closes the WINDOW_S-th second
module prm_tick_gen
  import prm_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
  parameter int unsigned WINDOW_S = DEF_WINDOW_S
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sec_tick,
  output logic win_end
);

  localparam int unsigned PW = cnt_width(CLK_HZ);
  localparam int unsigned WW = cnt_width(WINDOW_S);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [WW-1:0] WIN_MAX   = WW'(WINDOW_S - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [WW-1:0] win_q, win_d;

  assign sec_tick = run && (presc_q == PRESC_MAX);
  assign win_end  = sec_tick && (win_q == WIN_MAX);

  always_comb begin
    presc_d = presc_q;
    win_d   = win_q;
    if (!run) begin
      presc_d = '0;
      win_d   = '0;
    end else begin
      if (presc_q == PRESC_MAX) presc_d = '0;
      else                      presc_d = presc_q + 1'b1;
      if (sec_tick) begin
        if (win_q == WIN_MAX) win_d = '0;
        else                  win_d = win_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      win_q   <= '0;
    end else begin
      presc_q <= presc_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: rtl/pulse_rate_meter.sv
// Pulse-rate meter: counts rising edges of an async pulse over a timed window.
// Latency: pulse_in rise to count +1 is 3 cycles (3+DEB_CYC with the debounce filter).
// Backpressure: none; rate_valid is a one-cycle strobe with no handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, cls, mode  begin measurement / abort-clear / 0 single-shot, 1 continuous
//   pulse_in          asynchronous sensor pulse
//   thr_hi, thr_lo    live-count high alarm threshold / captured-rate low threshold (0 = off)
//   count, rate       live window count / last captured count
//   rate_valid        strobe in the cycle rate is updated
//   en_count          high while counting
//   alarm_hi          high while latched in the alarm state
//   alarm_lo          sticky low-rate flag, cleared by start or cls
//
// Build option: define PULSE_DEBOUNCE_EN to add a DEB_CYC-cycle stability
// filter between the synchroniser and the edge detector.
module pulse_rate_meter
  import prm_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
  parameter int unsigned WINDOW_S = DEF_WINDOW_S,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned DEB_CYC  = DEF_DEB_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cls,
  input  logic             mode,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic [CNT_W-1:0] thr_lo,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             en_count,
  output logic             alarm_hi,
  output logic             alarm_lo
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- input path ----------------
  logic sync1_q, sync2_q;
  logic filt;
  logic edge_q;
  logic inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
      edge_q  <= filt;
    end
  end

`ifdef PULSE_DEBOUNCE_EN
  localparam int unsigned DW = cnt_width(DEB_CYC);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC - 1);

  logic [DW-1:0] deb_cnt_q;
  logic          filt_q;

  // The filtered level only follows the synchronised level after it has
  // disagreed for DEB_CYC consecutive cycles; any agreement restarts the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt_q <= '0;
      filt_q    <= 1'b0;
    end else if (sync2_q == filt_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_MAX) begin
      deb_cnt_q <= '0;
      filt_q    <= sync2_q;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  assign filt = filt_q;
`else
  // Pass-through; DEB_CYC has no effect in this build.
  assign filt = (DEB_CYC != 0) ? sync2_q : sync2_q;
`endif

  assign inc = filt & ~edge_q;

  // ---------------- window timing ----------------
  state_e state_q;
  logic   sec_tick;
  logic   win_end;

  prm_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .WINDOW_S(WINDOW_S)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == S_COUNT),
    .sec_tick(sec_tick),
    .win_end (win_end)
  );

  // ---------------- counter and FSM ----------------
  logic [CNT_W-1:0] count_q, rate_q, count_sat;
  logic             rate_valid_q, en_count_q, alarm_hi_q, alarm_lo_q;

  // Next count including this cycle's edge, clamped at all-ones.
  always_comb begin
    count_sat = count_q;
    if (inc && (count_q != CNT_MAX)) count_sat = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      en_count_q   <= 1'b0;
      alarm_hi_q   <= 1'b0;
      alarm_lo_q   <= 1'b0;
    end else begin
      rate_valid_q <= 1'b0;
      if (cls) begin
        // Abort from anywhere; the last captured rate survives.
        state_q    <= S_IDLE;
        count_q    <= '0;
        en_count_q <= 1'b0;
        alarm_hi_q <= 1'b0;
        alarm_lo_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            count_q <= '0;
            if (start) begin
              state_q    <= S_COUNT;
              en_count_q <= 1'b1;
              alarm_lo_q <= 1'b0;
            end
          end
          S_COUNT: begin
            if (count_q > thr_hi) begin
              // Over-threshold beats a coinciding window end: no capture.
              state_q    <= S_ALARM;
              en_count_q <= 1'b0;
              alarm_hi_q <= 1'b1;
            end else if (sec_tick && win_end) begin
              // Capture on the way into CAPTURE so the strobe and the new
              // rate appear together, including an edge from this cycle.
              state_q      <= S_CAPTURE;
              en_count_q   <= 1'b0;
              count_q      <= count_sat;
              rate_q       <= count_sat;
              rate_valid_q <= 1'b1;
              alarm_lo_q   <= alarm_lo_q | ((thr_lo != '0) && (count_sat < thr_lo));
            end else begin
              count_q <= count_sat;
            end
          end
          S_CAPTURE: begin
            // Edges arriving here are dropped; the next window starts at zero.
            count_q <= '0;
            if (mode) begin
              state_q    <= S_COUNT;
              en_count_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_ALARM: begin
            // Count frozen, start ignored; only cls or reset leaves.
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign count      = count_q;
  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign en_count   = en_count_q;
  assign alarm_hi   = alarm_hi_q;
  assign alarm_lo   = alarm_lo_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Directed + randomised bench for pulse_rate_meter (8-bit/30-cycle and 4-bit/200-cycle builds).
// Latency: expectations derived from window length and input-path latency.
// Backpressure: n/a.
module tb_pulse_rate_meter;

`ifdef PULSE_DEBOUNCE_EN
  localparam int LAT = 7, PW = 4, PG = 4, N1 = 3, THR2 = 1, NMAX = 3;
  localparam int N3A = 1, N3B = 3, TLO3 = 2, GLITCH_EXP = 1;
`else
  localparam int LAT = 3, PW = 2, PG = 2, N1 = 5, THR2 = 3, NMAX = 5;
  localparam int N3A = 2, N3B = 6, TLO3 = 4, GLITCH_EXP = 2;
`endif
  localparam int WIN8 = 30, WIN4 = 200;

  logic       clk = 1'b0;
  logic       rst, start, cls, mode, pulse_in;
  logic [7:0] thr_hi, thr_lo, count, rate;
  logic       rate_valid, en_count, alarm_hi, alarm_lo;
  logic [3:0] thr_hi4, thr_lo4, count4, rate4;
  logic       rate_valid4, en_count4, alarm_hi4, alarm_lo4;

  int checks = 0, errors = 0;
  int cyc = 0, rv8 = 0, rv4 = 0;
  int entry, el, snap, exp8, exp_lo, n, tl, off;
  bit bad;

  pulse_rate_meter #(.CLK_HZ(10), .WINDOW_S(3), .CNT_W(8), .DEB_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cls(cls), .mode(mode), .pulse_in(pulse_in),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .count(count), .rate(rate), .rate_valid(rate_valid),
    .en_count(en_count), .alarm_hi(alarm_hi), .alarm_lo(alarm_lo));

  pulse_rate_meter #(.CLK_HZ(10), .WINDOW_S(20), .CNT_W(4), .DEB_CYC(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .cls(cls), .mode(mode), .pulse_in(pulse_in),
    .thr_hi(thr_hi4), .thr_lo(thr_lo4), .count(count4), .rate(rate4), .rate_valid(rate_valid4),
    .en_count(en_count4), .alarm_hi(alarm_hi4), .alarm_lo(alarm_lo4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rate_valid === 1'b1) rv8++;
    if (rate_valid4 === 1'b1) rv4++;
  endtask

  task automatic pulses(input int cnt, input int w, input int g);
    for (int i = 0; i < cnt; i++) begin
      pulse_in = 1'b1;
      repeat (w) step();
      pulse_in = 1'b0;
      if (i < cnt - 1) repeat (g) step();
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    entry = cyc;
  endtask

  task automatic do_cls();
    cls = 1'b1;
    step();
    cls = 1'b0;
  endtask

  // Steps until the chosen strobe is seen; returns cycles since entry or -1.
  task automatic wait_rv(input bit use4, input int budget, output int elapsed);
    elapsed = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if ((use4 ? rate_valid4 : rate_valid) === 1'b1) begin
        elapsed = cyc - entry;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; cls = 1'b0; mode = 1'b0; pulse_in = 1'b0;
    thr_hi = 8'd255; thr_lo = 8'd0; thr_hi4 = 4'hF; thr_lo4 = 4'h0;
    #12;
    // Reset state
    check("rst_count", count, 0);
    check("rst_rate", rate, 0);
    check("rst_flags", {rate_valid, en_count, alarm_hi, alarm_lo}, 0);
    check("rst_dut4", {count4, rate4, rate_valid4, en_count4, alarm_hi4, alarm_lo4}, 0);
    rst = 1'b1;
    step();

    // 1: single-shot window
    do_start();
    check("t1_en_count", en_count, 1);
    pulses(N1, PW, PG);
    wait_rv(1'b0, 40, el);
    check("t1_latency", el, WIN8);
    check("t1_rate", rate, N1);
    check("t1_count_in_capture", count, N1);
    step();
    check("t1_strobe_width", rate_valid, 0);
    check("t1_idle_en", en_count, 0);
    check("t1_idle_count", count, 0);

    // 2: overflow alarm
    snap = rv8;
    thr_hi = 8'(THR2);
    do_start();
    pulses(THR2, PW, PG);
    repeat (PG) step();
    pulse_in = 1'b1;
    repeat (LAT - 1) step();
    check("t2_count_before_latency", count, THR2);
    step();
    check("t2_count_reached", count, THR2 + 1);
    check("t2_alarm_not_yet", alarm_hi, 0);
    step();
    check("t2_alarm_rise", alarm_hi, 1);
    check("t2_en_off", en_count, 0);
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k == 10) pulse_in = 1'b0;
      if (k == 20) pulse_in = 1'b1;
      if (k == 28) pulse_in = 1'b0;
      start = (k == 50);
      step();
      if (alarm_hi !== 1'b1 || en_count !== 1'b0) bad = 1'b1;
    end
    start = 1'b0;
    check("t2_alarm_held", bad, 0);
    check("t2_count_frozen", count, THR2 + 1);
    do_cls();
    check("t2_cls_alarm", alarm_hi, 0);
    check("t2_cls_count", count, 0);
    check("t2_rate_kept", rate, N1);
    check("t2_no_strobe", rv8 - snap, 0);
    thr_hi = 8'd255;

    // 3: continuous mode with sticky low-rate flag, then randomised windows
    mode = 1'b1;
    thr_lo = 8'(TLO3);
    do_start();
    pulses(N3A, PW, PG);
    wait_rv(1'b0, 40, el);
    check("t3a_latency", el, WIN8);
    check("t3a_rate", rate, N3A);
    check("t3a_alarm_lo", alarm_lo, 1);
    step();
    entry = cyc;
    check("t3_reenter", en_count, 1);
    check("t3_count_cleared", count, 0);
    pulses(N3B, PW, PG);
    wait_rv(1'b0, 40, el);
    check("t3b_latency", el, WIN8);
    check("t3b_rate", rate, N3B);
    check("t3b_alarm_lo_sticky", alarm_lo, 1);
    exp_lo = 1;
    for (int w = 0; w < 6; w++) begin
      step();
      entry = cyc;
      n   = $urandom_range(NMAX, 0);
      tl  = $urandom_range(NMAX + 1, 0);
      off = $urandom_range(2, 0);
      thr_lo = 8'(tl);
      if (w == 5) mode = 1'b0;
      repeat (off) step();
      pulses(n, PW, PG);
      wait_rv(1'b0, 40, el);
      if (tl != 0 && n < tl) exp_lo = 1;
      check("t3r_latency", el, WIN8);
      check("t3r_rate", rate, n);
      check("t3r_alarm_lo", alarm_lo, exp_lo);
    end
    step();
    check("t3_single_idle", en_count, 0);
    do_start();
    check("t3_start_clears_lo", alarm_lo, 0);
    do_cls();

    // 4: saturation on the 4-bit build; 8-bit build captures what fits in 30 cycles
    mode = 1'b0;
    do_start();
    pulses(20, PW, PG);
    repeat (LAT) step();
    check("t4_sat_count", count4, 15);
    wait_rv(1'b1, 300, el);
    check("t4_latency4", el, WIN4);
    check("t4_sat_rate", rate4, 15);
    exp8 = 0;
    for (int i = 0; i < 20; i++) if (i * (PW + PG) + LAT <= WIN8) exp8++;
    check("t4_rate8", rate, exp8);

    // 5: cls coinciding with window end, then async reset mid-count
    snap = rv8;
    do_start();
    pulses(2, PW, PG);
    while (cyc < entry + WIN8 - 1) step();
    cls = 1'b1;
    step();
    cls = 1'b0;
    check("t5_cls_idle", en_count, 0);
    check("t5_cls_no_valid", rate_valid, 0);
    check("t5_cls_count", count, 0);
    repeat (3) step();
    check("t5_no_strobe", rv8 - snap, 0);
    check("t5_rate_kept", rate, exp8);
    do_start();
    pulses(2, PW, PG);
    repeat (LAT) step();
    check("t5_pre_reset_count", count, 2);
    #3;
    rst = 1'b0;
    #1;
    check("t5_async_rst", {count, rate, rate_valid, en_count, alarm_hi, alarm_lo}, 0);
    #2;
    rst = 1'b1;
    step();

    // 6: glitch rejection
    do_start();
    pulse_in = 1'b1;
    repeat (2) step();
    pulse_in = 1'b0;
    repeat (6) step();
    pulse_in = 1'b1;
    repeat (6) step();
    pulse_in = 1'b0;
    repeat (LAT + 1) step();
    check("t6_glitch_count", count, GLITCH_EXP);
    do_cls();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
